pipelined_addsub: RTL
=====================

Name: pipelined_addsub

Overview:
Parametrised, pipelined signed/unsigned adder-subtractor, successor to the 8-bit ripple add/sub used in the fixed-point Vedic multiplier datapath. The carry chain is split into SEG_W-bit segments with one register stage per segment, so wide accumulations (16/32-bit partial-product sums) close timing. Adds a valid/ready stream handshake, per-op add/sub mode, signed-overflow and carry/borrow flags, and optional signed saturation.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG_W (elaboration error otherwise)
SEG_W, 4, bits resolved per pipeline stage; NSEG = WIDTH/SEG_W = latency in cycles
SAT_EN, 0, 1 = clamp signed overflow to 0x7F..F / 0x80..0; 0 = wrap

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_sub  in  1  1 = A-B, 0 = A+B (B XORed with in_sub, in_sub is carry-in)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_s  out  WIDTH  sum/difference (saturated if SAT_EN and ovf)
out_cout  out  1  carry-out XOR sub: add = unsigned carry, sub = unsigned borrow (1 means A<B unsigned)
out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB (pre-saturation)

Behaviour:
- Reset: every stage valid bit cleared; all data/flag registers and out_s, out_cout, out_ovf = 0; out_valid = 0. in_ready = 1 in the cycle after reset deasserts. Reset mid-stream discards all in-flight ops; none emerge later.
- Pipeline enable en = ~out_valid | out_ready; in_ready = en (combinational). All stages advance together when en=1, hold when en=0 (global stall). Bubbles (valid=0) advance like data.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Stage k (0..NSEG-1) resolves bits [k*SEG_W +: SEG_W] using the registered carry from stage k-1 (stage 0 uses in_sub); higher unprocessed operand bits are skewed forward in registers, lower result bits delayed in registers so all bits of an op exit together.
- Latency: an op accepted at cycle t with no stall presents out_valid at t+NSEG. Throughput one op/cycle while out_ready=1.
- Final stage computes cout and ovf; if SAT_EN and ovf: out_s = MSB-of-A ? min negative : max positive (A sign decides since ovf only when effective operand signs match). out_cout unaffected by saturation.
- Order preserved; no op lost or duplicated under any in_valid/out_ready pattern.
- Simultaneous transfer in and out on a full pipe is legal (en=1 via out_ready).
- in_* values are don't-care when in_valid=0; out_* hold stable while out_valid & ~out_ready.
- NSEG=1 degenerates to a single registered add/sub with the same handshake.

Decomposition:
- Package addsub_pkg: ADD=1'b0 / SUB=1'b1 mode constants; function sat_value(sign, width) returning clamp constant.
- Sub-module addsub_segment: combinational SEG_W-bit ripple slice (a, b, sub, cin -> s, cout, c_msb_in) instantiated NSEG times via generate; the top holds only registers, handshake and saturation.

Test Plan:
- WIDTH=16 SEG_W=4 SAT_EN=0: 0x7FFF + 0x0001 add -> out_s=0x8000, ovf=1, cout=0, out_valid exactly 4 cycles after accept.
- Same op, SAT_EN=1 -> out_s=0x7FFF, ovf=1; and 0x8000 - 0x0001 -> out_s=0x8000, ovf=1, cout=0.
- 0x0003 - 0x0005 -> out_s=0xFFFE, cout=1 (borrow), ovf=0; 0xFFFF + 0x0001 -> 0x0000, cout=1, ovf=0 (carry crosses every segment).
- 32 random back-to-back ops with out_ready pseudo-random 50% -> outputs match golden model in order, count 32, out_s stable during stall.
- Pipe full with out_ready=0, then rst=1 for one cycle -> out_valid=0 and outputs 0 next cycle, no stale result ever emitted afterwards.
- WIDTH=8 SEG_W=8: 0x7F + 0x01 -> 0x80, ovf=1, latency 1 cycle; WIDTH=32 SEG_W=8 random regression, latency 4.

Source files
------------

// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and helpers for the pipelined adder-subtractor.
package addsub_pkg;

  // Operation mode, carried alongside each op as the in_sub bit.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Signed clamp constant for a given width: sign=0 -> max positive, sign=1 -> min negative.
  // Callers size-cast the result down to their own width.
  function automatic logic [63:0] sat_value(input logic sign, input int unsigned width);
    logic [63:0] v;
    v = 64'd1 << (width - 1);
    return sign ? v : (v - 64'd1);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_cout;
  logic             out_ovf;

  // Producer/consumer side driving operands and accepting results.
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_s, out_cout, out_ovf
  );

  // The adder-subtractor itself.
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_s, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_addsub_segment.sv
// Combinational SEG_W-bit ripple add/sub slice. B is inverted when i_sub is set; the
// caller supplies the carry-in (the op's sub bit for the lowest slice).
module addsub_segment
  import addsub_pkg::*;
#(
  parameter int unsigned SEG_W = 4
) (
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic [SEG_W-1:0] o_s,
  output logic             o_cout,
  output logic             o_c_msb_in
);

  logic [SEG_W-1:0] w_b;
  logic [SEG_W:0]   w_c;

  assign w_b = (i_sub == SUB) ? ~i_b : i_b;

  // Ripple carry through the slice, LSB first.
  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < int'(SEG_W); i++) begin
      o_s[i]   = i_a[i] ^ w_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & w_b[i]) | (w_c[i] & (i_a[i] ^ w_b[i]));
    end
  end

  assign o_cout     = w_c[SEG_W];
  // Carry into the slice MSB; only meaningful for the top slice (signed overflow).
  assign o_c_msb_in = w_c[SEG_W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined signed/unsigned adder-subtractor. The carry chain is cut every SEG_W bits with
// one register stage per slice; operands ride along unchanged and each stage overwrites its
// own slice of the running result, so all bits of an op leave the last stage together.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SEG_W  = 4,
  parameter bit          SAT_EN = 1'b0
) (
  input logic             clk,
  input logic             rst,
  pipelined_addsub_if.slave bus
);

  localparam int unsigned NSEG = WIDTH / SEG_W;
  localparam logic [WIDTH-1:0] SatPos = WIDTH'(sat_value(1'b0, WIDTH));
  localparam logic [WIDTH-1:0] SatNeg = WIDTH'(sat_value(1'b1, WIDTH));

  if ((WIDTH % SEG_W) != 0) begin : g_bad_width
    $error("pipelined_addsub: WIDTH must be a multiple of SEG_W");
  end

  // Per-stage registers; index k holds the state after slice k has been resolved.
  logic             r_vld [NSEG];
  logic             r_sub [NSEG];
  logic             r_c   [NSEG];
  logic [WIDTH-1:0] r_a   [NSEG];
  logic [WIDTH-1:0] r_b   [NSEG];
  logic [WIDTH-1:0] r_s   [NSEG];
  logic             r_cout;
  logic             r_ovf;

  // Stage inputs (from the bus for stage 0, else from the previous stage) and next state.
  logic             w_ivld [NSEG];
  logic             w_isub [NSEG];
  logic             w_icin [NSEG];
  logic [WIDTH-1:0] w_ia   [NSEG];
  logic [WIDTH-1:0] w_ib   [NSEG];
  logic [WIDTH-1:0] w_is   [NSEG];
  logic [WIDTH-1:0] w_ns   [NSEG];
  logic [SEG_W-1:0] w_seg_s   [NSEG];
  logic             w_seg_co  [NSEG];
  logic             w_seg_cmi [NSEG];

  logic w_en;
  logic w_cout;
  logic w_ovf;

  // Global stall: everything moves only when the output slot is free or being drained.
  assign w_en = ~r_vld[NSEG-1] | bus.out_ready;

  // Flags come from the top slice; cout is reported as borrow for subtraction.
  assign w_cout = w_seg_co[NSEG-1] ^ w_isub[NSEG-1];
  assign w_ovf  = w_seg_cmi[NSEG-1] ^ w_seg_co[NSEG-1];

  for (genvar k = 0; k < int'(NSEG); k++) begin : g_stage
    logic [WIDTH-1:0] w_merge;

    if (k == 0) begin : g_first
      assign w_ivld[k] = bus.in_valid;
      assign w_isub[k] = bus.in_sub;
      assign w_icin[k] = bus.in_sub;
      assign w_ia[k]   = bus.in_a;
      assign w_ib[k]   = bus.in_b;
      assign w_is[k]   = '0;
    end else begin : g_next
      assign w_ivld[k] = r_vld[k-1];
      assign w_isub[k] = r_sub[k-1];
      assign w_icin[k] = r_c[k-1];
      assign w_ia[k]   = r_a[k-1];
      assign w_ib[k]   = r_b[k-1];
      assign w_is[k]   = r_s[k-1];
    end

    addsub_segment #(
      .SEG_W (SEG_W)
    ) u_seg (
      .i_a        (w_ia[k][k*SEG_W +: SEG_W]),
      .i_b        (w_ib[k][k*SEG_W +: SEG_W]),
      .i_sub      (w_isub[k]),
      .i_cin      (w_icin[k]),
      .o_s        (w_seg_s[k]),
      .o_cout     (w_seg_co[k]),
      .o_c_msb_in (w_seg_cmi[k])
    );

    // Drop this stage's slice into the running result.
    always_comb begin
      w_merge                      = w_is[k];
      w_merge[k*SEG_W +: SEG_W]    = w_seg_s[k];
    end

    if (k == int'(NSEG) - 1) begin : g_last
      // Overflow needs matching effective operand signs, so A's sign picks the clamp.
      assign w_ns[k] = (SAT_EN && w_ovf) ? (w_ia[k][WIDTH-1] ? SatNeg : SatPos) : w_merge;
    end else begin : g_mid
      assign w_ns[k] = w_merge;
    end
  end

  // Advance all stages together; bubbles move like data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NSEG); k++) begin
        r_vld[k] <= 1'b0;
        r_sub[k] <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
      end
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < int'(NSEG); k++) begin
        r_vld[k] <= w_ivld[k];
        r_sub[k] <= w_isub[k];
        r_c[k]   <= w_seg_co[k];
        r_a[k]   <= w_ia[k];
        r_b[k]   <= w_ib[k];
        r_s[k]   <= w_ns[k];
      end
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_vld[NSEG-1];
  assign bus.out_s     = r_s[NSEG-1];
  assign bus.out_cout  = r_cout;
  assign bus.out_ovf   = r_ovf;

endmodule
